// File: rtl/ram_pin_arbiter_if.sv
// ram_pin_arbiter_if: requester handshakes, response and RAM pin bus of ram_pin_arbiter.
interface ram_pin_arbiter_if #(
  parameter int RAM_PINS = 4
) ();
  logic                req0_valid;
  logic [15:0]         req0_addr;
  logic                req0_ready;
  logic                req1_valid;
  logic [15:0]         req1_addr;
  logic                req1_ready;
  logic                rsp_valid;
  logic                rsp_id;
  logic [15:0]         rsp_data;
  logic [RAM_PINS-1:0] addr_pins;
  logic [RAM_PINS-1:0] data_pins;
  logic                busy;
  modport slave (
    input  req0_valid, req0_addr, req1_valid, req1_addr, data_pins,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, addr_pins, busy
  );
  modport master (
    output req0_valid, req0_addr, req1_valid, req1_addr, data_pins,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, addr_pins, busy
  );
endinterface

// File: rtl/ram_pin_arbiter.sv
// ram_pin_arbiter: two-port 16-bit read arbiter over a narrow serialized RAM pin bus.
// Define RAM_ARB_FAIRNESS_EN to cap consecutive port-0 grants while port 1 waits.
module ram_pin_arbiter #(
  parameter int RAM_PINS     = 4,
  parameter int READ_LATENCY = 2,
  parameter int MAX_WAIT     = 3
) (
  input logic clk,
  input logic reset,
  ram_pin_arbiter_if.slave bus
);
  localparam int NIB = 16 / RAM_PINS;
  localparam int CW  = $clog2(NIB + READ_LATENCY + 1);
  localparam logic [CW-1:0] K_NIB  = CW'(NIB - 1);
  localparam logic [CW-1:0] K_WAIT = CW'(READ_LATENCY < 2 ? 0 : READ_LATENCY - 2);
  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DATA} state_t;
  state_t state, state_nx;
  logic [CW-1:0] k, k_nx;
  logic [15:0] ash, d_nx;
  logic [15-RAM_PINS:0] dsh;
  logic id, force1, g0, g1, last;
  if (!(RAM_PINS == 1 || RAM_PINS == 2 || RAM_PINS == 4 || RAM_PINS == 8) ||
      READ_LATENCY < 1 || MAX_WAIT < 1) begin : g_bad_params
    $error("ram_pin_arbiter: unsupported parameter values");
  end
  assign g0 = !reset && state == IDLE && bus.req0_valid && !force1;
  assign g1 = !reset && state == IDLE && bus.req1_valid && (!bus.req0_valid || force1);
  assign bus.req0_ready = g0;
  assign bus.req1_ready = g1;
  assign bus.busy = state != IDLE;
  assign bus.addr_pins = state == ADDR ? ash[RAM_PINS-1:0] : '0;
  assign last = state == DATA && k == K_NIB;
  // earlier nibbles sit in dsh; the final one joins them straight from the pins
  assign d_nx = {bus.data_pins, dsh};
  always_comb begin
    state_nx = state;
    k_nx = k + CW'(1);
    case (state)
      IDLE: begin
        k_nx = '0;
        if (g0 || g1) state_nx = ADDR;
      end
      ADDR: if (k == K_NIB) begin
        state_nx = READ_LATENCY > 1 ? WAIT : DATA;
        k_nx = '0;
      end
      WAIT: if (k == K_WAIT) begin
        state_nx = DATA;
        k_nx = '0;
      end
      DATA: if (k == K_NIB) begin
        state_nx = IDLE;
        k_nx = '0;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k <= '0;
      ash <= '0;
      dsh <= '0;
      id <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= 1'b0;
      bus.rsp_data <= '0;
    end else begin
      state <= state_nx;
      k <= k_nx;
      bus.rsp_valid <= last;
      if (g0 || g1) begin
        ash <= g0 ? bus.req0_addr : bus.req1_addr;
        id <= g1;
      end else if (state == ADDR) ash <= ash >> RAM_PINS;
      if (state == DATA) dsh <= d_nx[15:RAM_PINS];
      if (last) begin
        bus.rsp_data <= d_nx;
        bus.rsp_id <= id;
      end
    end
  end
`ifdef RAM_ARB_FAIRNESS_EN
  localparam int FW = $clog2(MAX_WAIT + 1) < 2 ? 2 : $clog2(MAX_WAIT + 1);
  logic [FW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset || g1 || (g0 && !bus.req1_valid)) cnt <= '0;
    else if (g0) cnt <= cnt + FW'(1);
  end
  assign force1 = cnt == FW'(MAX_WAIT) && bus.req1_valid;
`else
  assign force1 = 1'b0;
`endif
endmodule
